// File: rtl/alu_pkg.sv
// Shared constants for the ALU result collector: source codes, default widths
// and the function-tag width.
package alu_pkg;

  localparam int OUT_WIDTH_DEF   = 32;
  localparam int ARITH_WIDTH_DEF = 32;
  localparam int LOGIC_WIDTH_DEF = 16;
  localparam int CMP_WIDTH_DEF   = 16;
  localparam int SHIFT_WIDTH_DEF = 17;
  localparam int DEPTH_DEF       = 4;

  localparam int FUN_WIDTH = 4;
  localparam int SRC_WIDTH = 2;

  // Source tag attached to every captured result.
  typedef enum logic [SRC_WIDTH-1:0] {
    SRC_ARITH = 2'd0,
    SRC_LOGIC = 2'd1,
    SRC_CMP   = 2'd2,
    SRC_SHIFT = 2'd3
  } src_t;

  // True when more than one unit enable is set in the same cycle.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO. The head entry is read combinationally from the
// storage array so it is visible the cycle after it is written. The head reads
// as zero while the FIFO is empty.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = OUT_WIDTH_DEF + SRC_WIDTH + FUN_WIDTH,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array write; contents need no reset because empty masks the head.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects the one active registered ALU unit result per cycle, tags it with
// its source and function code, and queues it for a valid/ready consumer.
// Flags dropped results and multiple simultaneous issues as sticky errors.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int ARITH_WIDTH = ARITH_WIDTH_DEF,
  parameter int LOGIC_WIDTH = LOGIC_WIDTH_DEF,
  parameter int CMP_WIDTH   = CMP_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ARITH_EN,
  input  logic                     LOGIC_EN,
  input  logic                     CMP_EN,
  input  logic                     SHIFT_EN,
  input  logic [FUN_WIDTH-1:0]     ALU_FUN,
  input  logic [ARITH_WIDTH-1:0]   ARITH_OUT,
  input  logic [LOGIC_WIDTH-1:0]   LOGIC_OUT,
  input  logic [CMP_WIDTH-1:0]     CMP_OUT,
  input  logic [SHIFT_WIDTH-1:0]   SHIFT_OUT,
  input  logic                     RES_READY,
  input  logic                     CLR_ERR,
  output logic                     RES_VALID,
  output logic [OUT_WIDTH-1:0]     RES_DATA,
  output logic [SRC_WIDTH-1:0]     RES_SRC,
  output logic [FUN_WIDTH-1:0]     RES_FUN,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY,
  output logic                     OVF_ERR,
  output logic                     MULTI_ERR
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = OUT_WIDTH + SRC_WIDTH + FUN_WIDTH;

  logic [3:0]           en_q;
  logic [FUN_WIDTH-1:0] fun_q;
  logic [OUT_WIDTH-1:0] sel_data;
  src_t                 sel_src;
  logic                 write_req;
  logic                 multi_event;
  logic                 ovf_event;
  logic                 pop_req;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        head;
  logic [CW-1:0]        busy_sum;

  // Stage 1: delay the issue strobes and function code to meet the unit outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q  <= '0;
      fun_q <= '0;
    end else begin
      en_q  <= {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN};
      fun_q <= ALU_FUN;
    end
  end

  // Stage 2 select: zero-extend the single active unit output and tag its source.
  always_comb begin
    sel_data  = '0;
    sel_src   = SRC_ARITH;
    write_req = 1'b0;
    case (en_q)
      4'b0001: begin sel_data = OUT_WIDTH'(ARITH_OUT); sel_src = SRC_ARITH; write_req = 1'b1; end
      4'b0010: begin sel_data = OUT_WIDTH'(LOGIC_OUT); sel_src = SRC_LOGIC; write_req = 1'b1; end
      4'b0100: begin sel_data = OUT_WIDTH'(CMP_OUT);   sel_src = SRC_CMP;   write_req = 1'b1; end
      4'b1000: begin sel_data = OUT_WIDTH'(SHIFT_OUT); sel_src = SRC_SHIFT; write_req = 1'b1; end
      default: ;
    endcase
  end

  assign multi_event = multi_hot(en_q);
  assign pop_req     = RES_VALID & RES_READY;
  assign ovf_event   = write_req & fifo_full & ~pop_req;

  alu_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (write_req),
    .wr_data ({sel_data, sel_src, fun_q}),
    .pop     (pop_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (COUNT)
  );

  assign RES_VALID = ~fifo_empty;
  assign RES_DATA  = head[EW-1 -: OUT_WIDTH];
  assign RES_SRC   = head[FUN_WIDTH +: SRC_WIDTH];
  assign RES_FUN   = head[FUN_WIDTH-1:0];

  // The result already in stage 2 counts against capacity so a compliant issuer never overflows.
  assign busy_sum = COUNT + CW'(|en_q);
  assign BUSY     = (busy_sum >= CW'(DEPTH));

  // Sticky error flags; a new error event beats a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVF_ERR   <= 1'b0;
      MULTI_ERR <= 1'b0;
    end else begin
      if (ovf_event)    OVF_ERR <= 1'b1;
      else if (CLR_ERR) OVF_ERR <= 1'b0;
      if (multi_event)  MULTI_ERR <= 1'b1;
      else if (CLR_ERR) MULTI_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_result_collector;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ARITH_EN = 0, LOGIC_EN = 0, CMP_EN = 0, SHIFT_EN = 0;
  logic [3:0]  ALU_FUN = '0;
  logic [31:0] ARITH_OUT = '0;
  logic [15:0] LOGIC_OUT = '0;
  logic [15:0] CMP_OUT = '0;
  logic [16:0] SHIFT_OUT = '0;
  logic        RES_READY = 0, CLR_ERR = 0;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic [1:0]  RES_SRC;
  logic [3:0]  RES_FUN;
  logic [2:0]  COUNT;
  logic        BUSY, OVF_ERR, MULTI_ERR;

  alu_result_collector dut (
    .CLK(CLK), .RST(RST),
    .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
    .ALU_FUN(ALU_FUN), .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .RES_READY(RES_READY), .CLR_ERR(CLR_ERR),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_SRC(RES_SRC), .RES_FUN(RES_FUN),
    .COUNT(COUNT), .BUSY(BUSY), .OVF_ERR(OVF_ERR), .MULTI_ERR(MULTI_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
    logic [3:0]  fun;
  } ent_t;

  // Reference model state.
  ent_t       mq[$];
  logic [3:0] m_pend_en  = '0;
  logic [3:0] m_pend_fun = '0;
  logic       m_ovf = 0, m_multi = 0;

  int    tests = 0;
  int    fails = 0;
  string phase = "reset";
  ent_t  saved_head;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend_en  = '0;
    m_pend_fun = '0;
    m_ovf      = 0;
    m_multi    = 0;
  endtask

  // One clock edge of the behaviour: pop, capture the single result issued last cycle, errors.
  task automatic model_edge();
    bit   pop;
    bit   ovf_set;
    bit   multi_set;
    int   n;
    ent_t e;
    pop       = (mq.size() != 0) && RES_READY;
    n         = $countones(m_pend_en);
    ovf_set   = 0;
    multi_set = (n > 1);
    if (pop) void'(mq.pop_front());
    if (n == 1) begin
      e.fun = m_pend_fun;
      if (m_pend_en[0])      begin e.data = ARITH_OUT;          e.src = 2'd0; end
      else if (m_pend_en[1]) begin e.data = {16'h0, LOGIC_OUT}; e.src = 2'd1; end
      else if (m_pend_en[2]) begin e.data = {16'h0, CMP_OUT};   e.src = 2'd2; end
      else                   begin e.data = {15'h0, SHIFT_OUT}; e.src = 2'd3; end
      if (mq.size() < DEPTH) mq.push_back(e);
      else ovf_set = 1;
    end
    if (ovf_set) m_ovf = 1; else if (CLR_ERR) m_ovf = 0;
    if (multi_set) m_multi = 1; else if (CLR_ERR) m_multi = 0;
    m_pend_en  = {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN};
    m_pend_fun = ALU_FUN;
  endtask

  task automatic check_all();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("valid", 64'(RES_VALID), 64'(mq.size() != 0));
    chk("count", 64'(COUNT), 64'(mq.size()));
    chk("data", 64'(RES_DATA), 64'(h.data));
    chk("src", 64'(RES_SRC), 64'(h.src));
    chk("fun", 64'(RES_FUN), 64'(h.fun));
    chk("busy", 64'(BUSY), 64'((mq.size() + ((m_pend_en != 0) ? 1 : 0)) >= DEPTH));
    chk("ovf", 64'(OVF_ERR), 64'(m_ovf));
    chk("multi", 64'(MULTI_ERR), 64'(m_multi));
    $display("[TB] %s t=%0t cnt=%0d valid=%0b data=%08h src=%0d fun=%0h busy=%0b ovf=%0b multi=%0b",
             phase, $time, COUNT, RES_VALID, RES_DATA, RES_SRC, RES_FUN, BUSY, OVF_ERR, MULTI_ERR);
  endtask

  // Advance one cycle: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) model_edge(); else model_reset();
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_en(input logic [3:0] en, input logic [3:0] fun);
    {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN} = en;
    ALU_FUN = fun;
  endtask

  task automatic rand_outs();
    ARITH_OUT = $urandom;
    LOGIC_OUT = 16'($urandom);
    CMP_OUT   = 16'($urandom);
    SHIFT_OUT = 17'($urandom);
  endtask

  initial begin
    logic [3:0] en;
    int r;

    // Reset state.
    model_reset();
    #12;
    check_all();
    @(negedge CLK);
    RST = 1;
    tick();

    // Shift result latency and zero-extension.
    phase = "shift";
    set_en(4'b1000, 4'hD);
    tick();
    set_en(4'b0000, 4'h0);
    SHIFT_OUT = 17'h1_0002;
    tick();
    chk("shift_valid", 64'(RES_VALID), 64'd1);
    chk("shift_data", 64'(RES_DATA), 64'h0001_0002);
    chk("shift_src", 64'(RES_SRC), 64'd3);
    chk("shift_fun", 64'(RES_FUN), 64'hD);
    RES_READY = 1;
    tick();
    RES_READY = 0;

    // Fill to capacity, then force an overflow.
    phase = "fill";
    for (int i = 0; i < 4; i++) begin
      set_en(4'b0001 << (i % 4), 4'(i + 1));
      rand_outs();
      tick();
    end
    set_en(4'b0000, 4'h0);
    rand_outs();
    tick();
    chk("full_count", 64'(COUNT), 64'd4);
    chk("full_busy", 64'(BUSY), 64'd1);
    saved_head = {RES_DATA, RES_SRC, RES_FUN};
    phase = "ovf";
    set_en(4'b0001, 4'h7);
    tick();
    set_en(4'b0000, 4'h0);
    rand_outs();
    tick();
    chk("ovf_flag", 64'(OVF_ERR), 64'd1);
    chk("ovf_count", 64'(COUNT), 64'd4);
    chk("ovf_head", 64'({RES_DATA, RES_SRC, RES_FUN}), 64'(saved_head));

    // Push and pop together while full, then drain across the pointer wrap.
    phase = "full_pushpop";
    set_en(4'b0010, 4'h9);
    tick();
    set_en(4'b0000, 4'h0);
    RES_READY = 1;
    rand_outs();
    tick();
    chk("pp_count", 64'(COUNT), 64'd4);
    phase = "drain";
    for (int i = 0; i < 5; i++) tick();
    RES_READY = 0;

    // Two enables together, then clear.
    phase = "multi";
    set_en(4'b0101, 4'h3);
    tick();
    set_en(4'b0000, 4'h0);
    tick();
    chk("multi_flag", 64'(MULTI_ERR), 64'd1);
    chk("multi_count", 64'(COUNT), 64'd0);
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;
    chk("multi_clr", 64'(MULTI_ERR), 64'd0);

    // Overflow and clear on the same edge: the overflow wins.
    phase = "ovf_clr";
    for (int i = 0; i < 4; i++) begin
      set_en(4'b0100, 4'(i));
      rand_outs();
      tick();
    end
    set_en(4'b1000, 4'hE);
    rand_outs();
    tick();
    set_en(4'b0000, 4'h0);
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;
    chk("ovf_clr_wins", 64'(OVF_ERR), 64'd1);
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;

    // Reset with entries queued and an enable in flight.
    phase = "mid_reset";
    RES_READY = 1;
    tick();
    RES_READY = 0;
    chk("pre_rst_count", 64'(COUNT), 64'd3);
    set_en(4'b0001, 4'h5);
    tick();
    RST = 0;
    #1;
    chk("rst_valid", 64'(RES_VALID), 64'd0);
    chk("rst_count", 64'(COUNT), 64'd0);
    model_reset();
    set_en(4'b0000, 4'h0);
    tick();
    RST = 1;
    tick();
    tick();
    chk("rst_inflight", 64'(COUNT), 64'd0);

    // Random traffic.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       en = 4'b0001 << $urandom_range(0, 3);
      else if (r == 4) en = 4'($urandom);
      else             en = 4'b0000;
      if (BUSY && ($urandom_range(0, 3) != 0)) en = 4'b0000;
      set_en(en, 4'($urandom));
      rand_outs();
      RES_READY = ($urandom_range(0, 2) != 0);
      CLR_ERR   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
